// File: rtl/mixer_pkg.sv
// Shared definitions for the N-voice stereo mixer: stereo codes, FSM encoding
// and the accumulator sizing rule.
package mixer_pkg;

  localparam logic [1:0] STEREO_CENTRE = 2'b00;
  localparam logic [1:0] STEREO_LEFT   = 2'b01;
  localparam logic [1:0] STEREO_RIGHT  = 2'b10;
  localparam logic [1:0] STEREO_MUTE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } mix_state_e;

  // One guard bit per doubling of voice count plus one spare, so a full sum never wraps.
  function automatic int acc_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices) + 1;
  endfunction

endpackage

// File: rtl/sample_saturator.sv
// Arithmetic right shift of a wide signed sum followed by a clamp to the
// signed OUT_W range. Purely combinational.
module sample_saturator #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_sum,
  input  logic        [2:0]       i_shift,
  output logic        [OUT_W-1:0] o_sample
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] w_shifted;

  assign w_shifted = i_sum >>> i_shift;

  always_comb begin
    if (w_shifted > MAX_V)      o_sample = MAX_V[OUT_W-1:0];
    else if (w_shifted < MIN_V) o_sample = MIN_V[OUT_W-1:0];
    else                        o_sample = w_shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/voice_mixer.sv
// N-voice stereo mixer: captures all voices on a strobe, accumulates one voice
// per cycle into left/right/mono sums, then shifts, saturates and registers.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES   = 3,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sample_in_valid,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
  input  logic [NUM_VOICES*2-1:0]            voice_stereo,
  input  logic                               stereo_on,
  input  logic [2:0]                         atten,
  output logic [SAMPLE_WIDTH-1:0]            sample_left,
  output logic [SAMPLE_WIDTH-1:0]            sample_right,
  output logic [SAMPLE_WIDTH-1:0]            sample_mono,
  output logic                               sample_out_valid,
  output logic                               busy,
  output logic                               overrun
);

  localparam int SW    = SAMPLE_WIDTH;
  localparam int ACC_W = acc_width(SAMPLE_WIDTH, NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  mix_state_e r_state, w_next;

  logic [IDX_W-1:0]               r_idx;
  logic [NUM_VOICES-1:0][SW-1:0]  r_samples;
  logic [NUM_VOICES-1:0][1:0]     r_codes;
  logic                           r_stereo_on;
  logic [2:0]                     r_atten;
  logic signed [ACC_W-1:0]        r_acc_l, r_acc_r, r_acc_m;
  logic [SW-1:0]                  r_left, r_right, r_mono;
  logic                           r_out_valid, r_overrun;

  logic                    w_capture, w_accum, w_emit, w_busy;
  logic [SW-1:0]           w_cur_sample;
  logic [1:0]              w_cur_code;
  logic signed [ACC_W-1:0] w_cur_ext;
  logic                    w_to_l, w_to_r, w_to_m;
  logic [SW-1:0]           w_sat_l, w_sat_r, w_sat_m;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (sample_in_valid) w_next = ST_ACCUM;
      ST_ACCUM:  if (r_idx == LAST_IDX) w_next = ST_OUTPUT;
      ST_OUTPUT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != ST_IDLE);
    w_capture = (r_state == ST_IDLE) && sample_in_valid;
    w_accum   = (r_state == ST_ACCUM);
    w_emit    = (r_state == ST_OUTPUT);
  end

  // Mux the current voice out of the capture registers.
  always_comb begin
    w_cur_sample = '0;
    w_cur_code   = STEREO_MUTE;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_sample = r_samples[i];
        w_cur_code   = r_codes[i];
      end
    end
  end

  assign w_cur_ext = {{(ACC_W-SW){w_cur_sample[SW-1]}}, w_cur_sample};

  // With stereo disabled, any non-muted code feeds both sides.
  always_comb begin
    w_to_m = (w_cur_code != STEREO_MUTE);
    w_to_l = w_to_m && (!r_stereo_on || (w_cur_code != STEREO_RIGHT));
    w_to_r = w_to_m && (!r_stereo_on || (w_cur_code != STEREO_LEFT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_samples   <= '0;
      r_codes     <= '0;
      r_stereo_on <= 1'b0;
      r_atten     <= '0;
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_acc_m     <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_mono      <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      if (sample_in_valid && w_busy) r_overrun <= 1'b1;
      if (w_capture) begin
        r_samples   <= voice_samples;
        r_codes     <= voice_stereo;
        r_stereo_on <= stereo_on;
        r_atten     <= atten;
        r_acc_l     <= '0;
        r_acc_r     <= '0;
        r_acc_m     <= '0;
        r_idx       <= '0;
      end
      if (w_accum) begin
        if (w_to_l) r_acc_l <= r_acc_l + w_cur_ext;
        if (w_to_r) r_acc_r <= r_acc_r + w_cur_ext;
        if (w_to_m) r_acc_m <= r_acc_m + w_cur_ext;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_emit) begin
        r_left  <= w_sat_l;
        r_right <= w_sat_r;
        r_mono  <= w_sat_m;
      end
    end
  end

  sample_saturator #(.IN_W(ACC_W), .OUT_W(SW)) u_sat_l (
    .i_sum(r_acc_l), .i_shift(r_atten), .o_sample(w_sat_l)
  );
  sample_saturator #(.IN_W(ACC_W), .OUT_W(SW)) u_sat_r (
    .i_sum(r_acc_r), .i_shift(r_atten), .o_sample(w_sat_r)
  );
  sample_saturator #(.IN_W(ACC_W), .OUT_W(SW)) u_sat_m (
    .i_sum(r_acc_m), .i_shift(r_atten), .o_sample(w_sat_m)
  );

  assign sample_left      = r_left;
  assign sample_right     = r_right;
  assign sample_mono      = r_mono;
  assign sample_out_valid = r_out_valid;
  assign busy             = w_busy;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed + randomised bench for voice_mixer at N=3, N=1 and N=16, with a
// per-instance scoreboard checked whenever a valid pulse appears.
module tb_voice_mixer;

  typedef struct {
    logic [15:0] l, r, m;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  logic reset;
  logic        iv3, iv1, iv16;
  logic [47:0] vs3;  logic [5:0]   vc3;
  logic [15:0] vs1;  logic [1:0]   vc1;
  logic [255:0] vs16; logic [31:0] vc16;
  logic st3, st1, st16;
  logic [2:0] at3, at1, at16;
  logic [15:0] l3, r3, m3, l1, r1, m1, l16, r16, m16;
  logic ov3, ov1, ov16, bz3, bz1, bz16, or3, or1, or16;

  voice_mixer #(.NUM_VOICES(3), .SAMPLE_WIDTH(16)) u3 (
    .clk(clk), .reset(reset), .sample_in_valid(iv3), .voice_samples(vs3),
    .voice_stereo(vc3), .stereo_on(st3), .atten(at3), .sample_left(l3),
    .sample_right(r3), .sample_mono(m3), .sample_out_valid(ov3), .busy(bz3),
    .overrun(or3));
  voice_mixer #(.NUM_VOICES(1), .SAMPLE_WIDTH(16)) u1 (
    .clk(clk), .reset(reset), .sample_in_valid(iv1), .voice_samples(vs1),
    .voice_stereo(vc1), .stereo_on(st1), .atten(at1), .sample_left(l1),
    .sample_right(r1), .sample_mono(m1), .sample_out_valid(ov1), .busy(bz1),
    .overrun(or1));
  voice_mixer #(.NUM_VOICES(16), .SAMPLE_WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .sample_in_valid(iv16), .voice_samples(vs16),
    .voice_stereo(vc16), .stereo_on(st16), .atten(at16), .sample_left(l16),
    .sample_right(r16), .sample_mono(m16), .sample_out_valid(ov16), .busy(bz16),
    .overrun(or16));

  exp_t q3[$], q1[$], q16[$];
  exp_t e3, e1, e16;
  logic [15:0] ts[16];
  logic [1:0]  tc[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic void ref_mix(input int n, input logic st, input logic [2:0] at,
                                  output logic [15:0] l, output logic [15:0] r,
                                  output logic [15:0] m);
    longint sl = 0, sr = 0, sm = 0, v;
    for (int i = 0; i < n; i++) begin
      v = longint'($signed(ts[i]));
      case (tc[i])
        2'b00: begin sl += v; sr += v; sm += v; end
        2'b01: begin sl += v; if (!st) sr += v; sm += v; end
        2'b10: begin sr += v; if (!st) sl += v; sm += v; end
        default: ;
      endcase
    end
    l = sat16(sl >>> at);
    r = sat16(sr >>> at);
    m = sat16(sm >>> at);
  endfunction

  // Drives a one-cycle strobe on the chosen instance, then scrambles its inputs.
  task automatic mix(input int which, input logic st, input logic [2:0] at, input bit push);
    exp_t e;
    int n;
    n = (which == 0) ? 3 : (which == 1) ? 1 : 16;
    ref_mix(n, st, at, e.l, e.r, e.m);
    @(negedge clk);
    e.due = cyc + n + 2;
    case (which)
      0: begin
        for (int i = 0; i < 3; i++) begin vs3[i*16 +: 16] = ts[i]; vc3[i*2 +: 2] = tc[i]; end
        st3 = st; at3 = at; iv3 = 1'b1;
        if (push) q3.push_back(e);
      end
      1: begin
        vs1 = ts[0]; vc1 = tc[0]; st1 = st; at1 = at; iv1 = 1'b1;
        if (push) q1.push_back(e);
      end
      default: begin
        for (int i = 0; i < 16; i++) begin vs16[i*16 +: 16] = ts[i]; vc16[i*2 +: 2] = tc[i]; end
        st16 = st; at16 = at; iv16 = 1'b1;
        if (push) q16.push_back(e);
      end
    endcase
    @(negedge clk);
    iv3 = 1'b0; iv1 = 1'b0; iv16 = 1'b0;
    for (int i = 0; i < 3; i++)  vs3[i*16 +: 16]  = 16'($urandom);
    for (int i = 0; i < 16; i++) vs16[i*16 +: 16] = 16'($urandom);
    vs1 = 16'($urandom); vc3 = 6'($urandom); vc1 = 2'($urandom); vc16 = $urandom;
    st3 = ~st3; st1 = ~st1; st16 = ~st16;
    at3 = 3'($urandom); at1 = 3'($urandom); at16 = 3'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while ((q3.size() + q1.size() + q16.size()) != 0 && k < 60) begin
      @(negedge clk); #1; k++;
    end
    chk("drain_pending", 32'(q3.size() + q1.size() + q16.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) if (ov3) begin
    checks++;
    assert (q3.size() != 0) else begin
      failures++; $error("FAIL u3_spurious_valid observed=1 expected=0");
    end
    if (q3.size() != 0) begin
      e3 = q3.pop_front();
      chk("u3_latency", 32'(cyc), 32'(e3.due));
      chk("u3_left", {16'd0, l3}, {16'd0, e3.l});
      chk("u3_right", {16'd0, r3}, {16'd0, e3.r});
      chk("u3_mono", {16'd0, m3}, {16'd0, e3.m});
    end
  end

  always @(negedge clk) if (ov1) begin
    checks++;
    assert (q1.size() != 0) else begin
      failures++; $error("FAIL u1_spurious_valid observed=1 expected=0");
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      chk("u1_latency", 32'(cyc), 32'(e1.due));
      chk("u1_left", {16'd0, l1}, {16'd0, e1.l});
      chk("u1_right", {16'd0, r1}, {16'd0, e1.r});
      chk("u1_mono", {16'd0, m1}, {16'd0, e1.m});
    end
  end

  always @(negedge clk) if (ov16) begin
    checks++;
    assert (q16.size() != 0) else begin
      failures++; $error("FAIL u16_spurious_valid observed=1 expected=0");
    end
    if (q16.size() != 0) begin
      e16 = q16.pop_front();
      chk("u16_latency", 32'(cyc), 32'(e16.due));
      chk("u16_left", {16'd0, l16}, {16'd0, e16.l});
      chk("u16_right", {16'd0, r16}, {16'd0, e16.r});
      chk("u16_mono", {16'd0, m16}, {16'd0, e16.m});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    iv3 = 0; iv1 = 0; iv16 = 0; vs3 = '0; vc3 = '0; vs1 = '0; vc1 = '0;
    vs16 = '0; vc16 = '0; st3 = 0; st1 = 0; st16 = 0; at3 = 0; at1 = 0; at16 = 0;
    for (int i = 0; i < 16; i++) begin ts[i] = '0; tc[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_left", {16'd0, l3}, 32'd0);
    chk("rst_right", {16'd0, r3}, 32'd0);
    chk("rst_mono", {16'd0, m3}, 32'd0);
    chk("rst_valid", {31'd0, ov3}, 32'd0);
    chk("rst_busy", {31'd0, bz3}, 32'd0);
    chk("rst_overrun", {31'd0, or3}, 32'd0);
    reset = 1'b0;

    // Basic stereo routing
    ts[0] = 16'd1000; ts[1] = 16'd2000; ts[2] = 16'd3000;
    tc[0] = 2'b00; tc[1] = 2'b01; tc[2] = 2'b10;
    mix(0, 1'b1, 3'd0, 1'b1);
    chk("busy_in_accum", {31'd0, bz3}, 32'd1);
    drain();
    chk("t1_left", {16'd0, l3}, 32'd3000);
    chk("t1_right", {16'd0, r3}, 32'd4000);
    chk("t1_mono", {16'd0, m3}, 32'd6000);
    chk("t1_busy_idle", {31'd0, bz3}, 32'd0);

    mix(0, 1'b0, 3'd0, 1'b1);
    drain();
    chk("t2_left", {16'd0, l3}, 32'd6000);
    chk("t2_right", {16'd0, r3}, 32'd6000);

    tc[1] = 2'b11;
    mix(0, 1'b0, 3'd0, 1'b1);
    drain();
    chk("t3_left", {16'd0, l3}, 32'd4000);
    chk("t3_mono", {16'd0, m3}, 32'd4000);

    // Saturation at both rails, and with attenuation
    for (int i = 0; i < 3; i++) begin ts[i] = 16'h7fff; tc[i] = 2'b00; end
    mix(0, 1'b1, 3'd0, 1'b1);
    drain();
    chk("sat_pos", {16'd0, m3}, 32'h7fff);
    for (int i = 0; i < 3; i++) ts[i] = 16'h8000;
    mix(0, 1'b1, 3'd0, 1'b1);
    drain();
    chk("sat_neg", {16'd0, l3}, 32'h8000);
    for (int i = 0; i < 3; i++) ts[i] = 16'h7fff;
    mix(0, 1'b1, 3'd2, 1'b1);
    drain();
    chk("atten2", {16'd0, r3}, 32'd24575);

    // Overrun: second strobe two cycles into the mix is ignored
    chk("ovr_clear", {31'd0, or3}, 32'd0);
    ts[0] = 16'd100; ts[1] = 16'd200; ts[2] = 16'd300;
    tc[0] = 2'b00; tc[1] = 2'b00; tc[2] = 2'b00;
    mix(0, 1'b1, 3'd0, 1'b1);
    @(negedge clk);
    vs3 = {16'd9, 16'd9, 16'd9}; vc3 = '0; iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    drain();
    chk("ovr_mono", {16'd0, m3}, 32'd600);
    chk("ovr_set", {31'd0, or3}, 32'd1);
    mix(0, 1'b1, 3'd0, 1'b1);
    drain();
    chk("ovr_sticky", {31'd0, or3}, 32'd1);

    // Reset in the second ACCUM cycle aborts the mix
    ts[0] = 16'd5; ts[1] = 16'd6; ts[2] = 16'd7;
    mix(0, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_valid", {31'd0, ov3}, 32'd0);
    chk("abort_left", {16'd0, l3}, 32'd0);
    chk("abort_mono", {16'd0, m3}, 32'd0);
    chk("abort_busy", {31'd0, bz3}, 32'd0);
    chk("abort_overrun", {31'd0, or3}, 32'd0);
    repeat (8) @(negedge clk);
    mix(0, 1'b1, 3'd0, 1'b1);
    drain();
    chk("post_reset_mono", {16'd0, m3}, 32'd18);

    // N=1 and N=16 sweeps against the reference model
    for (int it = 0; it < 10; it++) begin
      ts[0] = (it == 0) ? 16'h8000 : (it == 1) ? 16'h7fff : 16'($urandom);
      tc[0] = 2'(it % 4);
      mix(1, 1'($urandom), (it < 2) ? 3'd0 : 3'($urandom), 1'b1);
      drain();
    end
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 16; i++) begin
        ts[i] = (it == 0) ? 16'h7fff : (it == 1) ? 16'h8000 : 16'($urandom);
        tc[i] = (it < 2) ? 2'b00 : 2'($urandom);
      end
      mix(2, 1'($urandom), (it < 2) ? 3'd0 : 3'($urandom), 1'b1);
      drain();
    end
    chk("u1_no_overrun", {31'd0, or1}, 32'd0);
    chk("u16_no_overrun", {31'd0, or16}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
